// File: rtl/gate_sweep_pkg.sv
// Shared encodings and defaults for the gate sweep sequencer.
package gate_sweep_pkg;

    localparam int         NUM_VECTORS  = 8;
    localparam logic [2:0] LAST_VEC     = 3'(NUM_VECTORS - 1);
    localparam logic [4:0] DEFAULT_POLY = 5'b00101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/gate_sweep_misr.sv
// MISR signature register: folds one OUT_W sample per enabled cycle.
// One-cycle update latency; clear has priority over enable, no backpressure.
module gate_sweep_misr
    import gate_sweep_pkg::*;
#(
    parameter int               OUT_W = 5,
    parameter logic [OUT_W-1:0] POLY  = OUT_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] sig
);

    logic [OUT_W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Walks all 8 a/b/c vectors, settles, samples gate_out and builds a MISR; SETTLE_CYCLES+2 per vector.
// hold stalls settling only; start ignored while busy. GATE_SWEEP_COMPARE_EN adds the pass output.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int               OUT_W         = 5,
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [OUT_W-1:0] POLY          = OUT_W'(DEFAULT_POLY),
    parameter logic [OUT_W-1:0] EXPECTED_SIG  = OUT_W'(5'b00100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic [OUT_W-1:0] gate_out,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic [2:0]       vec_idx,
    output logic             sample_valid,
    output logic [OUT_W-1:0] sample_data,
    output logic [OUT_W-1:0] signature,
    output logic             done
`ifdef GATE_SWEEP_COMPARE_EN
    ,
    output logic             pass
`endif
);

    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] settle_cnt;
    logic       misr_clear;
    logic       misr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_APPLY;
                    misr_clear = 1'b1;
                end
            end
            ST_APPLY: begin
                state_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!hold && settle_cnt == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                misr_en    = 1'b1;
                state_next = (vec_idx == LAST_VEC) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Vector drive, settle counter and sample capture; a/b/c keep the last vector once idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a            <= 1'b0;
            b            <= 1'b0;
            c            <= 1'b0;
            vec_idx      <= 3'd0;
            settle_cnt   <= 8'd0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec_idx <= 3'd0;
                    end
                end
                ST_APPLY: begin
                    {a, b, c}  <= vec_idx;
                    settle_cnt <= 8'd0;
                end
                ST_SETTLE: begin
                    if (!hold) begin
                        settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    sample_data  <= gate_out;
                    sample_valid <= 1'b1;
                    if (vec_idx != LAST_VEC) begin
                        vec_idx <= vec_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    gate_sweep_misr #(
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .clear (misr_clear),
        .en    (misr_en),
        .din   (gate_out),
        .sig   (signature)
    );

`ifdef GATE_SWEEP_COMPARE_EN
    // The signature is already final by the DONE cycle, so compare the register itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            pass <= 1'b0;
        end else if (state == ST_DONE) begin
            pass <= (signature == EXPECTED_SIG);
        end
    end
`endif

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: two sequencers (settle 2 and settle 0) driving a looped-back gate stub.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start2 = 1'b0;
    logic start0 = 1'b0;
    logic hold = 1'b0;
    logic tie_one = 1'b0;
    logic sel = 1'b0;

    logic       a2, b2, c2, busy2, sv2, done2;
    logic [2:0] vi2;
    logic [4:0] sd2, sig2, go2;
    logic       a0, b0, c0, busy0, sv0, done0;
    logic [2:0] vi0;
    logic [4:0] sd0, sig0, go0;
`ifdef GATE_SWEEP_COMPARE_EN
    logic pass2, pass0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign go2 = tie_one ? 5'b00001 : {2'b00, a2, b2, c2};
    assign go0 = tie_one ? 5'b00001 : {2'b00, a0, b0, c0};

    gate_sweep_ctrl #(.OUT_W(5), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start2), .hold(hold), .gate_out(go2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .vec_idx(vi2),
        .sample_valid(sv2), .sample_data(sd2), .signature(sig2), .done(done2)
`ifdef GATE_SWEEP_COMPARE_EN
        , .pass(pass2)
`endif
    );

    gate_sweep_ctrl #(.OUT_W(5), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .hold(hold), .gate_out(go0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .vec_idx(vi0),
        .sample_valid(sv0), .sample_data(sd0), .signature(sig0), .done(done0)
`ifdef GATE_SWEEP_COMPARE_EN
        , .pass(pass0)
`endif
    );

    logic       m_busy, m_sv, m_done;
    logic [4:0] m_sd, m_sig;
    assign m_busy = sel ? busy0 : busy2;
    assign m_sv   = sel ? sv0   : sv2;
    assign m_done = sel ? done0 : done2;
    assign m_sd   = sel ? sd0   : sd2;
    assign m_sig  = sel ? sig0  : sig2;
`ifdef GATE_SWEEP_COMPARE_EN
    logic m_pass;
    assign m_pass = sel ? pass0 : pass2;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start0 = v;
        else     start2 = v;
    endtask

    // Runs one sweep on the selected DUT; cycle 0 is the cycle start is presented.
    task automatic sweep(input string tag, input bit hold_v3, input bit poke_start,
                         input bit chk_data, output int done_at);
        int n;
        int ns;
        done_at = -1;
        ns = 0;
        set_start(1'b1);
        tick();
        n = 1;
        set_start(1'b0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd1);
`ifdef GATE_SWEEP_COMPARE_EN
        chk({tag, "_pass_clr"}, 32'(m_pass), 32'd0);
`endif
        while (n < 200 && done_at < 0) begin
            if (m_sv) begin
                if (chk_data) chk({tag, "_sample"}, 32'(m_sd), 32'(ns));
                ns++;
            end
            if (m_done) done_at = n;
            hold = hold_v3 && (n >= 14) && (n < 19);
            set_start(poke_start && (n == 10));
            if (done_at < 0) begin
                tick();
                n++;
            end
        end
        hold = 1'b0;
        set_start(1'b0);
        chk({tag, "_nsamples"}, 32'(ns), 32'd8);
    endtask

    initial begin
        int d;
        bit seen;
        bit found;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_outs", {a2, b2, c2, busy2, vi2, sv2, sd2, sig2, done2}, 32'd0);
        chk("reset_outs0", {a0, b0, c0, busy0, vi0, sv0, sd0, sig0, done0}, 32'd0);
`ifdef GATE_SWEEP_COMPARE_EN
        chk("reset_pass", 32'(pass2), 32'd0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done2 || busy2) seen = 1'b1;
            tick();
        end
        chk("idle_no_done", 32'(seen), 32'd0);

        // Loopback data 0..7 gives signature 0x0F; a stray start mid-sweep is ignored.
        sweep("basic", 1'b0, 1'b1, 1'b1, d);
        chk("basic_done_cycle", 32'(d), 32'd33);
        chk("basic_sig", 32'(sig2), 32'h0F);
`ifdef GATE_SWEEP_COMPARE_EN
        chk("basic_pass", 32'(pass2), 32'd0);
`endif
        tick();
        chk("done_one_cycle", 32'(done2), 32'd0);
        chk("idle_busy", 32'(busy2), 32'd0);
        chk("idle_abc_hold", {29'd0, a2, b2, c2}, 32'd7);
        chk("idle_sig_hold", 32'(sig2), 32'h0F);

        tie_one = 1'b1;
        sweep("sig", 1'b0, 1'b0, 1'b0, d);
        chk("sig_done_cycle", 32'(d), 32'd33);
        chk("sig_value", 32'(sig2), 32'h04);
`ifdef GATE_SWEEP_COMPARE_EN
        tick();
        chk("sig_pass", 32'(pass2), 32'd1);
`endif
        tie_one = 1'b0;
        tick();

        sweep("hold", 1'b1, 1'b0, 1'b1, d);
        chk("hold_done_cycle", 32'(d), 32'd38);
        tick();

        sel = 1'b1;
        sweep("zero", 1'b0, 1'b0, 1'b1, d);
        chk("zero_done_cycle", 32'(d), 32'd17);
        chk("zero_sig", 32'(sig0), 32'h0F);
        sel = 1'b0;
        tick();

        // Abort at vector 4, then reset and start together, then a clean restart.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (vi2 == 3'd4) found = 1'b1;
            else tick();
        end
        chk("abort_reached_v4", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_outs", {a2, b2, c2, busy2, vi2, sv2, sd2, sig2, done2}, 32'd0);
        start2 = 1'b1;
        tick();
        reset = 1'b0;
        start2 = 1'b0;
        tick();
        chk("reset_beats_start", 32'(busy2), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done2) seen = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        sweep("restart", 1'b0, 1'b0, 1'b1, d);
        chk("restart_done_cycle", 32'(d), 32'd33);
        chk("restart_sig", 32'(sig2), 32'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
